// File: rtl/fpna_lif_cell.sv
// fpna_lif_cell
// -------------
// One configurable leaky integrate-and-fire neuron. It is also one segment of
// the serial configuration chain that programs the whole neuron array.
//
// Handshake: there is none. config_en is a level. While it is high, the cell
// shifts one configuration bit per clock and holds its neuron state at rest.
// While it is low, the cell integrates spike_in on every clock.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears everything, including cfg
//   reset_nn   synchronous active-low network reset; clears neuron state only
//   config_en  1 = shift the configuration chain and freeze the neuron
//   bs_in      serial configuration input; enters at cfg[CFG_LEN-1]
//   bs_out     serial configuration output; always cfg[0]
//   spike_in   input spikes, N_IN wide, sampled every clock
//   spike_out  registered output spike, one cycle per threshold crossing
//   v_mon      current membrane potential (signed), for debug
//
// cfg layout, LSB first:
//   weights (N_IN x W_BITS, signed) | thr (V_BITS, signed) | leak shift L (3)
//   | refractory R (3) | en (1) | mode (1)
module fpna_lif_cell #(
    parameter int N_IN    = 4,
    parameter int W_BITS  = 4,
    parameter int V_BITS  = 8,
    parameter int CFG_LEN = N_IN * W_BITS + V_BITS + 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reset_nn,
    input  logic              config_en,
    input  logic              bs_in,
    output logic              bs_out,
    input  logic [N_IN-1:0]   spike_in,
    output logic              spike_out,
    output logic [V_BITS-1:0] v_mon
);

    localparam int THR_LSB  = N_IN * W_BITS;
    localparam int L_LSB    = THR_LSB + V_BITS;
    localparam int R_LSB    = L_LSB + 3;
    localparam int EN_BIT   = R_LSB + 3;
    localparam int MODE_BIT = EN_BIT + 1;
    // Three guard bits cover v - leak + (sum of N_IN weights) without wrap.
    localparam int S_BITS   = V_BITS + 3;

    localparam logic signed [S_BITS-1:0] VMAX_S = S_BITS'((1 << (V_BITS - 1)) - 1);
    localparam logic signed [S_BITS-1:0] VMIN_S = ~VMAX_S;

    logic [CFG_LEN-1:0]       cfg_q, cfg_d;
    logic signed [V_BITS-1:0] v_q, v_d;
    logic [2:0]               refr_q, refr_d;
    logic                     spike_q, spike_d;

    // Decoded configuration fields
    logic signed [V_BITS-1:0] thr;
    logic [2:0]               l_shift;
    logic [2:0]               r_len;
    logic                     en;
    logic                     mode;

    // Integration datapath
    logic signed [W_BITS-1:0] w_cur;
    logic signed [S_BITS-1:0] sum;
    logic signed [S_BITS-1:0] v_ext;
    logic signed [S_BITS-1:0] lk;
    logic signed [S_BITS-1:0] raw;
    logic signed [V_BITS-1:0] sat_v;
    logic signed [S_BITS-1:0] diff;
    logic signed [V_BITS-1:0] sub_v;
    logic                     fire;

    function automatic logic signed [V_BITS-1:0] clamp(input logic signed [S_BITS-1:0] x);
        logic signed [V_BITS-1:0] r;
        if (x > VMAX_S) begin
            r = VMAX_S[V_BITS-1:0];
        end else if (x < VMIN_S) begin
            r = VMIN_S[V_BITS-1:0];
        end else begin
            r = x[V_BITS-1:0];
        end
        return r;
    endfunction

    always_comb begin
        thr     = cfg_q[THR_LSB +: V_BITS];
        l_shift = cfg_q[L_LSB +: 3];
        r_len   = cfg_q[R_LSB +: 3];
        en      = cfg_q[EN_BIT];
        mode    = cfg_q[MODE_BIT];

        sum   = '0;
        w_cur = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_cur = cfg_q[i * W_BITS +: W_BITS];
            if (spike_in[i]) begin
                sum = sum + {{(S_BITS - W_BITS){w_cur[W_BITS-1]}}, w_cur};
            end
        end

        v_ext = {{(S_BITS - V_BITS){v_q[V_BITS-1]}}, v_q};

        // Leak is the arithmetic (flooring) shift of v; L=0 disables it.
        // Written as an if so the shift stays in a purely signed expression.
        lk = '0;
        if (l_shift != 3'd0) begin
            lk = v_ext >>> l_shift;
        end

        raw   = v_ext - lk + sum;
        sat_v = clamp(raw);
        fire  = (sat_v >= thr);
        diff  = {{(S_BITS - V_BITS){sat_v[V_BITS-1]}}, sat_v}
              - {{(S_BITS - V_BITS){thr[V_BITS-1]}}, thr};
        sub_v = clamp(diff);
    end

    always_comb begin
        cfg_d   = cfg_q;
        v_d     = v_q;
        refr_d  = refr_q;
        spike_d = 1'b0;

        if (config_en) begin
            cfg_d = {bs_in, cfg_q[CFG_LEN-1:1]};
        end

        if (config_en || !reset_nn || !en) begin
            v_d    = '0;
            refr_d = '0;
        end else if (refr_q != 3'd0) begin
            refr_d = refr_q - 3'd1;
        end else if (fire) begin
            spike_d = 1'b1;
            refr_d  = r_len;
            v_d     = mode ? sub_v : '0;
        end else begin
            v_d = sat_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q   <= '0;
            v_q     <= '0;
            refr_q  <= '0;
            spike_q <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            v_q     <= v_d;
            refr_q  <= refr_d;
            spike_q <= spike_d;
        end
    end

    assign bs_out    = cfg_q[0];
    assign spike_out = spike_q;
    assign v_mon     = v_q;

endmodule
